gold_burst_scheduler: RTL and testbench
=======================================

// Module: gold_burst_scheduler
// PURPOSE
// Shares the single Gold code generator between N_REQ requesters. Arbitrates requests
// round-robin, loads the winner's seed into the generator and meters out a burst of chips.
// Each burst is req_len chips long and is streamed on an AXI-Stream master with backpressure.
// Sits between the channel logic and the Gold generator / AXI-Stream sink; clocked at clkin.
// PARAMETERS
// N_REQ    4   number of requesters (>=2)
// LFSR_W   5   generator LFSR width; code period P = 2**LFSR_W - 1 chips
// LEN_W    16  width of burst-length field
// PORTS
// clkin          in   1              system clock (100 MHz domain)
// rst            in   1              asynchronous reset, active-high
// req_i          in   N_REQ          level request per requester
// req_seed_i     in   N_REQ*LFSR_W   per-requester seed, slice i = [i*LFSR_W +: LFSR_W]
// req_len_i      in   N_REQ*LEN_W    per-requester burst length in chips
// grant_o        out  N_REQ          one-hot; high for whole service of requester
// done_o         out  N_REQ          1-cycle pulse at end of service
// busy_o         out  1              high in any state except IDLE
// gen_load_o     out  1              1-cycle seed load strobe to generator
// gen_seed_o     out  LFSR_W         seed for gen_load_o (0 substituted by 1)
// gen_en_o       out  1              advance generator by one chip
// gen_chip_i     in   1              current generator chip (combinational from its state)
// m_axis_tdata   out  8              bit0 = chip, [7:1] = 0
// m_axis_tvalid  out  1
// m_axis_tready  in   1
// m_axis_tlast   out  1              last chip of burst
// m_axis_tuser   out  $clog2(N_REQ)  index of granted requester
// strobe_o       out  1              1-cycle pulse on handshake of a chip at period index 0
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, RR pointer=0, counters 0; mid-burst reset discards burst, no done.
// - FSM IDLE->LOAD->RUN->DRAIN->DONE->IDLE; len=0 takes IDLE->DONE directly (no load, no beats).
// - IDLE: if |req_i, pick first set req at/after pointer (wrapping); latch seed, len, id.
// - Arbitration: pointer <= id+1 (mod N_REQ) in DONE.
// - IDLE->LOAD: grant_o[id] rises in the same registered cycle; grant stays high through DONE.
// - LOAD: gen_load_o=1, gen_seed_o=latched seed, one cycle.
// - RUN: gen_en_o = (!m_axis_tvalid | m_axis_tready) & (issued < len).
//   On gen_en_o, capture gen_chip_i into output register: tvalid<=1, issued++.
//   tlast<=1 when the captured chip is number len. After the last capture go DRAIN.
//   If no capture and tready, tvalid<=0.
// - DRAIN: hold until tvalid & tready & tlast; then tvalid<=0, tlast<=0 -> DONE.
// - DONE: done_o[id]=1 one cycle, grant cleared -> IDLE.
//   Requester must drop req_i after done or is re-served when its turn recurs.
// - AXI rules: tdata/tlast/tuser stable while tvalid & !tready; tvalid never depends on tready
//   combinationally; at most one chip buffered.
// - Latency: req sampled at edge k -> grant_o/gen_load_o at k+1, first gen_en_o at k+2,
//   first tvalid at k+3. Full throughput 1 chip/cycle with tready=1.
// - Period counter: mod P over handshaken chips, cleared at LOAD. strobe_o registered,
//   asserted the cycle after a handshake with index 0.
// - req_i/seed/len changes after latch are ignored until next arbitration.
// - Requests arriving during a burst wait; no preemption.
// TESTING
// 1 req_i=0001, seed 5'h01, len 31, tready=1 -> 31 beats contiguous from k+3, chips match Gold
//   model, tlast on beat 31, tuser=0, one strobe, done_o=0001 one cycle.
// 2 as 1 with tready 1,0,1,0... -> 31 beats exactly, data stable when stalled,
//   gen_en_o count=31, no duplicates.
// 3 req_i=1111 all len 3 held until done -> grants 0,1,2,3 in order;
//   then req_i=0101 -> grants 0,2,0,2.
// 4 req_i=0010, len 0 -> done_o=0010 at k+1, no gen_load_o, no tvalid.
// 5 len 62 seed 5'h1F -> strobe_o after beat 1 and beat 32; tlast on beat 62.
// 6 rst pulse at beat 10 of len-31 burst -> outputs 0 asynchronously, no done.
//   After release, req_i=0100 -> grant_o=0100, full fresh burst.

Source files
------------

// File: rtl/gold_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : gold_burst_scheduler_if
// Brief    : AXI-Stream chip channel between the burst scheduler and its sink.
// Revision : 1.0 - initial release
// ============================================================================
interface gold_burst_scheduler_if #(
    parameter int ID_W = 2
);
    logic [7:0]      tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic [ID_W-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/gold_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gold_burst_scheduler
// Brief    : Round-robin sharing of one Gold code generator; streams bursts.
// Revision : 1.0 - initial release
// ============================================================================
module gold_burst_scheduler #(
    parameter int N_REQ  = 4,
    parameter int LFSR_W = 5,
    parameter int LEN_W  = 16
) (
    input  wire logic                      clkin,
    input  wire logic                      rst,
    input  wire logic [N_REQ-1:0]          req_i,
    input  wire logic [N_REQ*LFSR_W-1:0]   req_seed_i,
    input  wire logic [N_REQ*LEN_W-1:0]    req_len_i,
    output logic      [N_REQ-1:0]          grant_o,
    output logic      [N_REQ-1:0]          done_o,
    output logic                           busy_o,
    output logic                           gen_load_o,
    output logic      [LFSR_W-1:0]         gen_seed_o,
    output logic                           gen_en_o,
    input  wire logic                      gen_chip_i,
    gold_burst_scheduler_if.master         m_axis,
    output logic                           strobe_o
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [LFSR_W-1:0] c_PER_LAST = LFSR_W'((2 ** LFSR_W) - 2);
    localparam logic [ID_W-1:0]   c_ID_LAST  = ID_W'(N_REQ - 1);

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [LFSR_W-1:0] seed_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic              chip_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [LFSR_W-1:0] per_q;
    logic              strobe_q;

    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic              wrap_vld;
    logic [ID_W-1:0]   wrap_id;
    logic [LFSR_W-1:0] sel_seed;
    logic [LEN_W-1:0]  sel_len;
    logic              gen_en;
    logic              hs;
    logic              last_cap;

    // Lowest set request at/after the pointer wins; otherwise wrap to lowest set request.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        wrap_vld = 1'b0;
        wrap_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                wrap_vld = 1'b1;
                wrap_id  = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    pick_vld = 1'b1;
                    pick_id  = ID_W'(i);
                end
            end
        end
        if (!pick_vld) begin
            pick_vld = wrap_vld;
            pick_id  = wrap_id;
        end
    end

    always_comb begin
        sel_seed = '0;
        sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                sel_seed = req_seed_i[i*LFSR_W +: LFSR_W];
                sel_len  = req_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign hs       = tvalid_q & m_axis.tready;
    assign last_cap = (issued_q + LEN_W'(1)) == len_q;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (pick_vld) begin
                    state_d = (sel_len == '0) ? c_DONE : c_LOAD;
                end
            end
            c_LOAD:  state_d = c_RUN;
            c_RUN: begin
                if (gen_en && last_cap) begin
                    state_d = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (hs && tlast_q) begin
                    state_d = c_DONE;
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Generator advances only when the single-entry output register can take a chip.
    always_comb begin
        busy_o     = (state_q != c_IDLE);
        grant_o    = busy_o ? (N_REQ'(1) << id_q) : '0;
        done_o     = (state_q == c_DONE) ? (N_REQ'(1) << id_q) : '0;
        gen_load_o = (state_q == c_LOAD);
        gen_seed_o = '0;
        if (state_q == c_LOAD) begin
            gen_seed_o = (seed_q == '0) ? LFSR_W'(1) : seed_q;
        end
        gen_en = (state_q == c_RUN) && (!tvalid_q || m_axis.tready) && (issued_q < len_q);
        gen_en_o = gen_en;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            id_q     <= '0;
            seed_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            chip_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (pick_vld) begin
                        id_q     <= pick_id;
                        seed_q   <= sel_seed;
                        len_q    <= sel_len;
                        issued_q <= '0;
                    end
                end
                c_RUN: begin
                    if (gen_en) begin
                        chip_q   <= gen_chip_i;
                        tvalid_q <= 1'b1;
                        tlast_q  <= last_cap;
                        issued_q <= issued_q + LEN_W'(1);
                    end else if (m_axis.tready) begin
                        tvalid_q <= 1'b0;
                    end
                end
                c_DRAIN: begin
                    if (hs && tlast_q) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                end
                c_DONE: begin
                    ptr_q <= (id_q == c_ID_LAST) ? '0 : id_q + ID_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Code-period position of handshaken chips; strobe marks chip index 0.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            per_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= hs && (per_q == '0);
            if (state_q == c_LOAD) begin
                per_q <= '0;
            end else if (hs) begin
                per_q <= (per_q == c_PER_LAST) ? '0 : per_q + LFSR_W'(1);
            end
        end
    end

    assign strobe_o      = strobe_q;
    assign m_axis.tdata  = {7'b0, chip_q};
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = id_q;

endmodule
`default_nettype wire

// File: tb/tb_gold_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gold_burst_scheduler
// Brief    : Directed self-checking bench for gold_burst_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gold_burst_scheduler;

    localparam int N_REQ  = 4;
    localparam int LFSR_W = 5;
    localparam int LEN_W  = 16;
    localparam int ID_W   = 2;

    logic                      clkin = 1'b0;
    logic                      rst   = 1'b1;
    logic [N_REQ-1:0]          req_i = '0;
    logic [N_REQ*LFSR_W-1:0]   req_seed_i = '0;
    logic [N_REQ*LEN_W-1:0]    req_len_i = '0;
    logic [N_REQ-1:0]          grant_o;
    logic [N_REQ-1:0]          done_o;
    logic                      busy_o;
    logic                      gen_load_o;
    logic [LFSR_W-1:0]         gen_seed_o;
    logic                      gen_en_o;
    logic                      gen_chip_i;
    logic                      strobe_o;

    gold_burst_scheduler_if #(.ID_W(ID_W)) axis_if ();

    gold_burst_scheduler #(.N_REQ(N_REQ), .LFSR_W(LFSR_W), .LEN_W(LEN_W)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .req_i      (req_i),
        .req_seed_i (req_seed_i),
        .req_len_i  (req_len_i),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .gen_load_o (gen_load_o),
        .gen_seed_o (gen_seed_o),
        .gen_en_o   (gen_en_o),
        .gen_chip_i (gen_chip_i),
        .m_axis     (axis_if),
        .strobe_o   (strobe_o)
    );

    always #5 clkin = ~clkin;

    // Gold generator: two 5-bit LFSRs, second one fixed at all-ones on load.
    function automatic logic [4:0] step_a(input logic [4:0] s);
        return {s[0] ^ s[2], s[4:1]};
    endfunction
    function automatic logic [4:0] step_b(input logic [4:0] s);
        return {s[0] ^ s[1] ^ s[2] ^ s[3], s[4:1]};
    endfunction
    function automatic logic gold_exp(input logic [4:0] seed, input int n);
        logic [4:0] a;
        logic [4:0] b;
        a = (seed == 5'd0) ? 5'd1 : seed;
        b = 5'h1F;
        for (int k = 0; k < n; k++) begin
            a = step_a(a);
            b = step_b(b);
        end
        return a[0] ^ b[0];
    endfunction

    logic [4:0] ga = 5'h01;
    logic [4:0] gb = 5'h1F;
    always @(posedge clkin) begin
        if (gen_load_o) begin
            ga <= gen_seed_o;
            gb <= 5'h1F;
        end else if (gen_en_o) begin
            ga <= step_a(ga);
            gb <= step_b(gb);
        end
    end
    assign gen_chip_i = ga[0] ^ gb[0];

    int tready_mode = 0;
    initial begin
        axis_if.tready = 1'b1;
        forever begin
            @(posedge clkin);
            #1;
            if (tready_mode == 0) axis_if.tready = 1'b1;
            else                  axis_if.tready = ~axis_if.tready;
        end
    end

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    int         hs_cyc_q[$];
    logic       hs_data_q[$];
    logic       hs_last_q[$];
    int         hs_user_q[$];
    int         grant_cyc_q[$];
    logic [3:0] grant_val_q[$];
    int         done_cyc_q[$];
    logic [3:0] done_val_q[$];
    int         load_cyc_q[$];
    logic [4:0] load_seed_q[$];
    int         en_cyc_q[$];
    int         strobe_at_q[$];
    int         tvalid_cycles = 0;
    int         viol = 0;
    logic [3:0] prev_grant = '0;
    logic [3:0] prev_done  = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic [1:0] prev_user  = '0;

    always @(negedge clkin) begin
        if (rst) begin
            prev_grant = '0;
            prev_done  = '0;
            prev_stall = 1'b0;
        end else begin
            if (strobe_o) strobe_at_q.push_back(hs_cyc_q.size());
            if (prev_stall && (!axis_if.tvalid || axis_if.tdata != prev_data ||
                               axis_if.tlast != prev_last || axis_if.tuser != prev_user))
                viol++;
            if (done_o != '0) begin
                if (prev_done != '0) viol++;
                done_cyc_q.push_back(cyc);
                done_val_q.push_back(done_o);
            end
            if (grant_o != '0 && prev_grant == '0) begin
                grant_cyc_q.push_back(cyc);
                grant_val_q.push_back(grant_o);
            end
            if (gen_load_o) begin
                load_cyc_q.push_back(cyc);
                load_seed_q.push_back(gen_seed_o);
            end
            if (gen_en_o) en_cyc_q.push_back(cyc);
            if (axis_if.tvalid) tvalid_cycles++;
            if (axis_if.tvalid && axis_if.tready) begin
                hs_cyc_q.push_back(cyc);
                hs_data_q.push_back(axis_if.tdata[0]);
                hs_last_q.push_back(axis_if.tlast);
                hs_user_q.push_back(int'(axis_if.tuser));
            end
            prev_grant = grant_o;
            prev_done  = done_o;
            prev_stall = axis_if.tvalid && !axis_if.tready;
            prev_data  = axis_if.tdata;
            prev_last  = axis_if.tlast;
            prev_user  = axis_if.tuser;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Beats b0..b0+n-1 must carry the Gold sequence for seed, tlast only on the last, tuser=id.
    function automatic int burst_errs(input int b0, input int n, input logic [4:0] seed, input int id);
        int e;
        e = 0;
        for (int i = 0; i < n; i++) begin
            if (b0 + i >= hs_cyc_q.size()) begin
                e++;
            end else begin
                if (hs_data_q[b0+i] !== gold_exp(seed, i)) e++;
                if (hs_last_q[b0+i] !== (i == n - 1)) e++;
                if (hs_user_q[b0+i] != id) e++;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clkin);
        #2;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int d0;
        int k;
        d0 = done_cyc_q.size();
        k = 0;
        while (done_cyc_q.size() < d0 + n && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, done_cyc_q.size() - d0, n);
    endtask

    task automatic drive_at_posedge(input logic [3:0] req);
        @(posedge clkin);
        #1;
        req_i = req;
    endtask

    int t0, b0, g0, d0, l0, e0, s0, v0, tv0;
    int errs;
    logic [3:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

    task automatic snap();
        t0  = cyc;
        b0  = hs_cyc_q.size();
        g0  = grant_cyc_q.size();
        d0  = done_cyc_q.size();
        l0  = load_cyc_q.size();
        e0  = en_cyc_q.size();
        s0  = strobe_at_q.size();
        v0  = viol;
        tv0 = tvalid_cycles;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_val("rst_outputs", {3'b0, grant_o, done_o, busy_o, gen_load_o, gen_en_o, strobe_o,
                                  axis_if.tvalid, axis_if.tlast, axis_if.tdata, axis_if.tuser,
                                  gen_seed_o}, 32'd0);
        @(posedge clkin);
        #1;
        rst = 1'b0;
        repeat (2) tick();

        // 1: single requester, seed 1, len 31, tready always high
        req_seed_i[4:0] = 5'h01;
        req_len_i[15:0] = 16'd31;
        drive_at_posedge(4'b0001);
        snap();
        wait_dones("t1_done_seen", 1, 200);
        drive_at_posedge(4'b0000);
        check_val("t1_grant", (grant_val_q.size() > g0) ? grant_val_q[g0] : 4'hF, 4'b0001);
        check_val("t1_grant_lat", (grant_cyc_q.size() > g0) ? grant_cyc_q[g0] - t0 : -1, 1);
        check_val("t1_load_lat", (load_cyc_q.size() > l0) ? load_cyc_q[l0] - t0 : -1, 1);
        check_val("t1_en_lat", (en_cyc_q.size() > e0) ? en_cyc_q[e0] - t0 : -1, 2);
        check_val("t1_tvalid_lat", (hs_cyc_q.size() > b0) ? hs_cyc_q[b0] - t0 : -1, 3);
        check_val("t1_beats", hs_cyc_q.size() - b0, 31);
        check_val("t1_contiguous", (hs_cyc_q.size() >= b0 + 31) ? hs_cyc_q[b0+30] - hs_cyc_q[b0] : -1, 30);
        check_val("t1_content", burst_errs(b0, 31, 5'h01, 0), 0);
        check_val("t1_strobes", strobe_at_q.size() - s0, 1);
        check_val("t1_done_val", (done_val_q.size() > d0) ? done_val_q[d0] : 4'hF, 4'b0001);
        check_val("t1_viol", viol - v0, 0);

        // 2: same burst with alternating tready
        repeat (2) tick();
        tready_mode = 1;
        drive_at_posedge(4'b0001);
        snap();
        wait_dones("t2_done_seen", 1, 300);
        drive_at_posedge(4'b0000);
        tready_mode = 0;
        check_val("t2_beats", hs_cyc_q.size() - b0, 31);
        check_val("t2_content", burst_errs(b0, 31, 5'h01, 0), 0);
        check_val("t2_gen_en", en_cyc_q.size() - e0, 31);
        check_val("t2_stable", viol - v0, 0);

        // 3: round-robin, fresh pointer after a reset pulse
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        @(posedge clkin);
        #1;
        rst = 1'b0;
        req_seed_i = {5'd9, 5'd7, 5'd5, 5'd3};
        req_len_i  = {4{16'd3}};
        drive_at_posedge(4'b1111);
        snap();
        wait_dones("t3a_dones", 4, 200);
        drive_at_posedge(4'b0101);
        wait_dones("t3b_dones", 4, 200);
        drive_at_posedge(4'b0000);
        for (int j = 0; j < 8; j++) begin
            int id;
            id = 0;
            for (int q = 0; q < 4; q++) if (exp_g[j][q]) id = q;
            check_val($sformatf("t3_grant%0d", j), (grant_val_q.size() > g0 + j) ? grant_val_q[g0+j] : 4'hF, exp_g[j]);
            check_val($sformatf("t3_burst%0d", j), burst_errs(b0 + 3*j, 3, 5'(3 + 2*id), id), 0);
        end

        // 4: zero-length burst goes straight to done
        repeat (2) tick();
        req_len_i[31:16] = 16'd0;
        drive_at_posedge(4'b0010);
        snap();
        wait_dones("t4_done_seen", 1, 50);
        drive_at_posedge(4'b0000);
        check_val("t4_done_val", (done_val_q.size() > d0) ? done_val_q[d0] : 4'hF, 4'b0010);
        check_val("t4_done_lat", (done_cyc_q.size() > d0) ? done_cyc_q[d0] - t0 : -1, 1);
        check_val("t4_no_load", load_cyc_q.size() - l0, 0);
        check_val("t4_no_tvalid", tvalid_cycles - tv0, 0);

        // 5: two code periods, strobes on beats 1 and 32
        repeat (2) tick();
        req_seed_i[19:15] = 5'h1F;
        req_len_i[63:48]  = 16'd62;
        drive_at_posedge(4'b1000);
        snap();
        wait_dones("t5_done_seen", 1, 300);
        drive_at_posedge(4'b0000);
        check_val("t5_beats", hs_cyc_q.size() - b0, 62);
        check_val("t5_content", burst_errs(b0, 62, 5'h1F, 3), 0);
        check_val("t5_strobes", strobe_at_q.size() - s0, 2);
        check_val("t5_strobe_a", (strobe_at_q.size() > s0) ? strobe_at_q[s0] - b0 : -1, 1);
        check_val("t5_strobe_b", (strobe_at_q.size() > s0 + 1) ? strobe_at_q[s0+1] - b0 : -1, 32);

        // 6: asynchronous reset mid-burst, then a fresh burst with seed 0
        repeat (2) tick();
        req_seed_i[4:0] = 5'h03;
        req_len_i[15:0] = 16'd31;
        drive_at_posedge(4'b0001);
        snap();
        begin
            int k;
            k = 0;
            while (hs_cyc_q.size() - b0 < 10 && k < 100) begin
                tick();
                k++;
            end
        end
        check_val("t6_reached_beat10", hs_cyc_q.size() - b0, 10);
        rst = 1'b1;
        req_i = '0;
        #1;
        check_val("t6_async_zero", {3'b0, grant_o, done_o, busy_o, gen_load_o, gen_en_o, strobe_o,
                                    axis_if.tvalid, axis_if.tlast, axis_if.tdata, axis_if.tuser,
                                    gen_seed_o}, 32'd0);
        @(posedge clkin);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        check_val("t6_no_done", done_cyc_q.size() - d0, 0);
        req_seed_i[14:10] = 5'h00;
        req_len_i[47:32]  = 16'd31;
        drive_at_posedge(4'b0100);
        snap();
        wait_dones("t6_done_seen", 1, 200);
        drive_at_posedge(4'b0000);
        check_val("t6_grant", (grant_val_q.size() > g0) ? grant_val_q[g0] : 4'hF, 4'b0100);
        check_val("t6_seed_sub", (load_seed_q.size() > l0) ? load_seed_q[l0] : 5'h1F, 5'h01);
        check_val("t6_beats", hs_cyc_q.size() - b0, 31);
        check_val("t6_content", burst_errs(b0, 31, 5'h00, 2), 0);
        check_val("t6_done_val", (done_val_q.size() > d0) ? done_val_q[d0] : 4'hF, 4'b0100);
        check_val("all_protocol_viol", viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
